adder_err_monitor: RTL and testbench

ADDER_ERR_MONITOR -- requirements
Module: adder_err_monitor

---
 rtl/adder_err_monitor.sv | 95 +++++++++
 tb/tb_adder_err_monitor.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_err_monitor.sv
// Measures error statistics of an approximate adder over a window of WINDOW samples; stats settle 2 cycles after each accept.
// Samples are accepted only in RUN; the REPORT result is held until OUT_READY, and new samples stall meanwhile.
module adder_err_monitor #(
    parameter  int ADDER_SIZE = 8,
    parameter  int WINDOW     = 256,
    localparam int CNT_W      = $clog2(WINDOW + 1),
    localparam int SUM_W      = ADDER_SIZE + 1 + CNT_W
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  START,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [ADDER_SIZE-1:0] A,
    input  logic [ADDER_SIZE-1:0] B,
    input  logic                  CIN,
    input  logic [ADDER_SIZE-1:0] SUM,
    input  logic                  COUT,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [CNT_W-1:0]      ERR_CNT,
    output logic [ADDER_SIZE:0]   MAX_ED,
    output logic [SUM_W-1:0]      SUM_ED,
    output logic                  BUSY
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, REPORT} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic                  s1_vld_q;
    logic [ADDER_SIZE:0]   exact_q;
    logic [ADDER_SIZE:0]   approx_q;
    logic [CNT_W-1:0]      err_cnt_q;
    logic [ADDER_SIZE:0]   max_ed_q;
    logic [SUM_W-1:0]      sum_ed_q;
    logic                  accept;
    logic [ADDER_SIZE:0]   ed;

    assign IN_READY  = (state_q == RUN);
    assign OUT_VALID = (state_q == REPORT);
    assign BUSY      = (state_q == RUN) || (state_q == DRAIN);
    assign ERR_CNT   = err_cnt_q;
    assign MAX_ED    = max_ed_q;
    assign SUM_ED    = sum_ed_q;

    assign accept = IN_VALID && IN_READY;
    assign ed     = (exact_q >= approx_q) ? (exact_q - approx_q) : (approx_q - exact_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (START) state_d = RUN;
            RUN:     if (accept && (cnt_q == LAST)) state_d = DRAIN;
            // The last sample is still in stage 1 on DRAIN entry; wait until it has retired.
            DRAIN:   if (!s1_vld_q) state_d = REPORT;
            REPORT:  if (OUT_READY) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            s1_vld_q  <= 1'b0;
            exact_q   <= '0;
            approx_q  <= '0;
            err_cnt_q <= '0;
            max_ed_q  <= '0;
            sum_ed_q  <= '0;
        end else begin
            state_q  <= state_d;
            s1_vld_q <= accept;
            if (accept) begin
                exact_q  <= {1'b0, A} + {1'b0, B} + {{ADDER_SIZE{1'b0}}, CIN};
                approx_q <= {COUT, SUM};
                cnt_q    <= cnt_q + CNT_W'(1);
            end
            if ((state_q == IDLE) && START) begin
                cnt_q     <= '0;
                err_cnt_q <= '0;
                max_ed_q  <= '0;
                sum_ed_q  <= '0;
            end else if (s1_vld_q) begin
                sum_ed_q <= sum_ed_q + SUM_W'(ed);
                if (ed > max_ed_q) max_ed_q <= ed;
                if (ed != '0) err_cnt_q <= err_cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_adder_err_monitor.sv
// Bench for adder_err_monitor (ADDER_SIZE=8, WINDOW=4): directed scenarios plus random windows vs. a window-level model.
module tb_adder_err_monitor;

    localparam int AW  = 8;
    localparam int WIN = 4;
    localparam int CW  = 3;
    localparam int SW  = 12;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          START = 1'b0;
    logic          IN_VALID = 1'b0;
    logic          IN_READY;
    logic [AW-1:0] A = '0;
    logic [AW-1:0] B = '0;
    logic          CIN = 1'b0;
    logic [AW-1:0] SUM = '0;
    logic          COUT = 1'b0;
    logic          OUT_VALID;
    logic          OUT_READY = 1'b0;
    logic [CW-1:0] ERR_CNT;
    logic [AW:0]   MAX_ED;
    logic [SW-1:0] SUM_ED;
    logic          BUSY;

    int n_tests = 0;
    int n_fail  = 0;
    int sa[WIN], sb[WIN], sc[WIN], ss[WIN], so[WIN];
    int exp_err, exp_max, exp_sum;

    adder_err_monitor #(.ADDER_SIZE(AW), .WINDOW(WIN)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .A(A), .B(B), .CIN(CIN), .SUM(SUM), .COUT(COUT), .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY), .ERR_CNT(ERR_CNT), .MAX_ED(MAX_ED), .SUM_ED(SUM_ED), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference: error distance of each sample from plain integer arithmetic, folded over the window.
    task automatic model_window();
        int ex, ap, d;
        exp_err = 0; exp_max = 0; exp_sum = 0;
        for (int i = 0; i < WIN; i++) begin
            ex = sa[i] + sb[i] + sc[i];
            ap = so[i] * (1 << AW) + ss[i];
            d  = (ex > ap) ? ex - ap : ap - ex;
            if (d != 0) exp_err++;
            if (d > exp_max) exp_max = d;
            exp_sum += d;
        end
    endtask

    task automatic set_samp(input int i, input int a, input int b, input int c, input int s, input int o);
        sa[i] = a; sb[i] = b; sc[i] = c; ss[i] = s; so[i] = o;
    endtask

    task automatic rand_samp(input int i);
        int ex, ap;
        sa[i] = $urandom_range(0, 255);
        sb[i] = $urandom_range(0, 255);
        sc[i] = $urandom_range(0, 1);
        ex = sa[i] + sb[i] + sc[i];
        ap = ($urandom_range(0, 2) == 0) ? ex : $urandom_range(0, 511);
        ss[i] = ap % 256;
        so[i] = ap / 256;
    endtask

    task automatic send_window(input int nsamp, input bit gaps, input bit start_mid);
        @(negedge CLK); START = 1'b1;
        @(negedge CLK); START = 1'b0;
        chk("run_ready", IN_READY, 1);
        for (int i = 0; i < nsamp; i++) begin
            if (gaps) begin
                IN_VALID = 1'b0;
                A = AW'($urandom); B = AW'($urandom); SUM = AW'($urandom); COUT = 1'b1; CIN = 1'b1;
                @(negedge CLK);
            end
            IN_VALID = 1'b1;
            A = AW'(sa[i]); B = AW'(sb[i]); CIN = sc[i][0]; SUM = AW'(ss[i]); COUT = so[i][0];
            if (start_mid && i == 1) START = 1'b1;
            @(negedge CLK);
            START = 1'b0;
        end
        IN_VALID = 1'b0;
        if (nsamp == WIN) begin
            chk("drain_ready", IN_READY, 0);
            chk("drain_busy", BUSY, 1);
        end
    endtask

    task automatic wait_report();
        int t = 0;
        while (!OUT_VALID && t < 12) begin
            @(negedge CLK);
            t++;
        end
        chk("report_reached", OUT_VALID, 1);
        model_window();
        chk("err_cnt", ERR_CNT, exp_err);
        chk("max_ed", MAX_ED, exp_max);
        chk("sum_ed", SUM_ED, exp_sum);
        chk("report_busy", BUSY, 0);
    endtask

    task automatic release_report(input int hold, input bit start_hs);
        OUT_READY = 1'b0;
        for (int k = 0; k < hold; k++) begin
            @(negedge CLK);
            chk("hold_valid", OUT_VALID, 1);
            chk("hold_in_ready", IN_READY, 0);
            chk("hold_err", ERR_CNT, exp_err);
            chk("hold_max", MAX_ED, exp_max);
            chk("hold_sum", SUM_ED, exp_sum);
        end
        OUT_READY = 1'b1;
        START = start_hs;
        @(negedge CLK);
        OUT_READY = 1'b0;
        START = 1'b0;
        chk("idle_valid", OUT_VALID, 0);
        chk("idle_busy", BUSY, 0);
        @(negedge CLK);
        chk("idle_in_ready", IN_READY, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"}, IN_READY, 0);
        chk({tag, "_out_valid"}, OUT_VALID, 0);
        chk({tag, "_busy"}, BUSY, 0);
        chk({tag, "_err"}, ERR_CNT, 0);
        chk({tag, "_max"}, MAX_ED, 0);
        chk({tag, "_sum"}, SUM_ED, 0);
    endtask

    initial begin
        #12;
        check_all_zero("reset");
        @(negedge CLK); RST_N = 1'b1;

        // No sample may be taken after reset until START.
        IN_VALID = 1'b1; A = 8'h55; B = 8'h22; SUM = 8'h00;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            chk("no_start_ready", IN_READY, 0);
        end
        IN_VALID = 1'b0;

        for (int i = 0; i < WIN; i++) set_samp(i, 'h0F, 'h01, 0, 'h10, 0);
        send_window(WIN, 1'b0, 1'b0);
        wait_report();
        chk("exact_err_const", ERR_CNT, 0);
        release_report(0, 1'b0);

        set_samp(0, 'hF0, 'hF0, 0, 'hE0, 1);
        set_samp(1, 'hF0, 'hF0, 1, 'hD1, 1);
        set_samp(2, 'h01, 'h01, 0, 'h03, 0);
        set_samp(3, 'h12, 'h34, 1, 'h47, 0);
        send_window(WIN, 1'b0, 1'b0);
        wait_report();
        chk("mixed_err_const", ERR_CNT, 2);
        chk("mixed_max_const", MAX_ED, 'h010);
        chk("mixed_sum_const", SUM_ED, 17);
        release_report(5, 1'b1);

        send_window(WIN, 1'b1, 1'b1);
        wait_report();
        release_report(2, 1'b0);

        // Reset in the middle of a window, then a fresh window.
        set_samp(0, 'h80, 'h80, 0, 'h00, 0);
        set_samp(1, 'h10, 'h10, 0, 'hFF, 1);
        send_window(2, 1'b0, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        chk("mid_busy", BUSY, 1);
        #2 RST_N = 1'b0;
        #1 check_all_zero("mid_reset");
        @(negedge CLK); RST_N = 1'b1;
        for (int i = 0; i < WIN; i++) set_samp(i, 'h20 + i, 'h03, 1, 'h24 + i, 0);
        send_window(WIN, 1'b0, 1'b0);
        wait_report();
        release_report(1, 1'b0);

        // Reset while a report is pending.
        for (int i = 0; i < WIN; i++) rand_samp(i);
        send_window(WIN, 1'b0, 1'b0);
        wait_report();
        #2 RST_N = 1'b0;
        #1 check_all_zero("report_reset");
        @(negedge CLK); RST_N = 1'b1;

        for (int w = 0; w < 20; w++) begin
            for (int i = 0; i < WIN; i++) rand_samp(i);
            send_window(WIN, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            wait_report();
            release_report($urandom_range(0, 3), $urandom_range(0, 1) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
